// File: rtl/sim_uart_rx_pkg.sv
// ============================================================================
// Module : sim_uart_pkg
// Desc   : Shared types, widths and baud helper for the sim UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sim_uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

   function automatic int clks_per_bit(input longint clk_hz, input longint baud);
      return int'(clk_hz / baud);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sim_uart_rx_fifo.sv
// ============================================================================
// Module : sim_uart_rx_fifo
// Desc   : Byte FIFO with wrap-bit pointers; push+pop when full both proceed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sim_uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
         $error("sim_uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign data_o    = mem_q[rd_ptr_q[AW-1:0]];
   // When full, a concurrent pop frees the head slot that the push overwrites.
   assign w_do_pop  = pop_i && !empty_o;
   assign w_do_push = push_i && (!full_o || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sim_uart_rx.sv
// ============================================================================
// Module : sim_uart_rx
// Desc   : Oversampling 8N1 UART receiver with valid/ready byte output.
//          Define SIM_UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sim_uart_rx
   import sim_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_rx,
   output logic [UART_DATA_W-1:0] o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_frame_err,
   output logic                   o_overrun,
   output logic                   o_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_cfg_check
         $error("sim_uart_rx: CLKS_PER_BIT must be >= 4");
      end
   endgenerate

   logic [1:0]             sync_q;
   logic                   w_rx;
   uart_rx_state_t         state_q,     state_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic [2:0]             bit_idx_q,   bit_idx_d;
   logic [UART_DATA_W-1:0] shift_q,     shift_d;
   logic                   frame_err_q, frame_err_d;
   logic                   w_cnt_zero;
   logic                   w_push;
   logic                   overrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_rx};
      end
   end

   assign w_rx       = sync_q[1];
   assign w_cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      w_push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_rx) begin
               state_d = START;
               cnt_d   = CNT_HALF;
            end
         end
         START: begin
            if (!w_cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (w_rx) begin
               state_d = IDLE;
            end else begin
               state_d   = DATA;
               bit_idx_d = '0;
               cnt_d     = CNT_BIT;
            end
         end
         DATA: begin
            if (!w_cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {w_rx, shift_q[UART_DATA_W-1:1]};
               cnt_d   = CNT_BIT;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (!w_cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (w_rx) begin
               w_push  = 1'b1;
               state_d = IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = BREAK;
            end
         end
         BREAK: begin
            // Hold off until the line returns high so a long break is not a start bit.
            if (w_rx) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_busy      = (state_q != IDLE);
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

`ifdef SIM_UART_RX_FIFO_EN
   logic w_full;
   logic w_empty;
   logic w_pop;

   assign w_pop   = !w_empty && i_ready;
   assign o_valid = !w_empty;

   sim_uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .data_i  (shift_q),
      .pop_i   (w_pop),
      .data_o  (o_data),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= w_push && w_full && !w_pop;
      end
   end
`else
   logic [UART_DATA_W-1:0] data_q;
   logic                   valid_q;
   logic                   w_unused_depth;

   assign w_unused_depth = (FIFO_DEPTH != 0);
   assign o_data         = data_q;
   assign o_valid        = valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= w_push && valid_q && !i_ready;
         if (w_push) begin
            // A held, unaccepted byte wins; the new one is dropped.
            if (!(valid_q && !i_ready)) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end
`endif

endmodule

`default_nettype wire
